pll_reset_seq: RTL



---
 rtl/pll_reset_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//   Reset and lock sequencer for the core clock PLL, clocked by the free-running
//   board reference clock. It pulses the PLL reset, waits for the synchronized
//   lock indication and holds it for a settle interval before releasing the
//   system reset of the PLL-clocked logic. Loss of lock re-runs the sequence.
//
// Configuration macro: PLL_LOCK_TIMEOUT_EN
//   defined   : lock wait is bounded by LOCK_TIMEOUT, failed attempts are
//               counted in `retries`, and MAX_RETRY failures end in FAULT.
//   undefined : lock wait is unbounded, FAULT does not exist, and `fault`
//               and `retries` are constant 0.
// -----------------------------------------------------------------------------
module pll_reset_seq #(
   parameter int RST_PULSE    = 16,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int SETTLE       = 1024,
   parameter int MAX_RETRY    = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retries
);

   // Largest interval the shared counter must cover.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   localparam int CNT_MAX = max3(RST_PULSE, LOCK_TIMEOUT, SETTLE);
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   // Terminal counts: the counter is 0 on the first cycle after a state entry,
   // so an interval of K cycles ends when the counter holds K-1.
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
`ifdef PLL_LOCK_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [3:0]       MAX_R4       = 4'(MAX_RETRY);
`endif

   // FSM encoding.
   localparam logic [2:0] ST_PLL_RST   = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_SETTLE    = 3'd2;
   localparam logic [2:0] ST_RUN       = 3'd3;
`ifdef PLL_LOCK_TIMEOUT_EN
   localparam logic [2:0] ST_FAULT     = 3'd4;
`endif

   // Elaboration-time parameter range checks.
   if (RST_PULSE < 1) begin : g_chk_rst_pulse
      $error("pll_reset_seq: RST_PULSE must be >= 1");
   end
   if (LOCK_TIMEOUT < 1) begin : g_chk_lock_timeout
      $error("pll_reset_seq: LOCK_TIMEOUT must be >= 1");
   end
   if (SETTLE < 1) begin : g_chk_settle
      $error("pll_reset_seq: SETTLE must be >= 1");
   end
   if ((MAX_RETRY < 1) || (MAX_RETRY > 15)) begin : g_chk_max_retry
      $error("pll_reset_seq: MAX_RETRY must be in 1..15");
   end

   logic             sync1_q;
   logic             lock_s_q;
   logic [2:0]       state_q;
   logic [2:0]       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             pll_rst_q;
   logic             sys_reset_q;
   logic             ready_q;
`ifdef PLL_LOCK_TIMEOUT_EN
   logic [3:0]       retries_q;
   logic [3:0]       retries_d;
   logic             fault_q;

   // Failed-attempt count never wraps; it stops at MAX_RETRY.
   function automatic logic [3:0] retry_inc(input logic [3:0] r);
      if (r >= MAX_R4) begin
         return MAX_R4;
      end
      return r + 4'd1;
   endfunction
`endif

   // Two-flop synchronizer bringing the raw PLL lock into the refclk domain.
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= pll_locked;
         lock_s_q <= sync1_q;
      end
   end

   // Next-state, counter and retry decode; the counter restarts on every state change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
`ifdef PLL_LOCK_TIMEOUT_EN
      retries_d = retries_q;
`endif
      case (state_q)
         ST_PLL_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         ST_WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
            end else if (cnt_q == TIMEOUT_LAST) begin
               cnt_d     = '0;
               retries_d = retry_inc(retries_q);
               if (retry_inc(retries_q) == MAX_R4) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_PLL_RST;
               end
            end
`else
            end else begin
               // Unbounded wait: hold the counter instead of letting it wrap.
               cnt_d = cnt_q;
            end
`endif
         end
         ST_SETTLE: begin
            if (!lock_s_q) begin
               // Bounce during settle: restart the lock wait, attempt not counted.
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
               retries_d = 4'd0;
`endif
            end
         end
         ST_RUN: begin
            cnt_d = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
            retries_d = 4'd0;
`endif
            if (!lock_s_q) begin
               state_d = ST_PLL_RST;
            end
         end
`ifdef PLL_LOCK_TIMEOUT_EN
         ST_FAULT: begin
            // Terminal until rst; counter parked.
            cnt_d = '0;
         end
`endif
         default: begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and retry registers; rst forces a fresh PLL reset pulse.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q <= ST_PLL_RST;
         cnt_q   <= '0;
`ifdef PLL_LOCK_TIMEOUT_EN
         retries_q <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef PLL_LOCK_TIMEOUT_EN
         retries_q <= retries_d;
`endif
      end
   end

   // Outputs registered from the next state so they change on the same edge as the state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         pll_rst_q   <= 1'b1;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
         fault_q     <= 1'b0;
`endif
      end else begin
         pll_rst_q   <= (state_d == ST_PLL_RST);
         sys_reset_q <= (state_d != ST_RUN);
         ready_q     <= (state_d == ST_RUN);
`ifdef PLL_LOCK_TIMEOUT_EN
         fault_q     <= (state_d == ST_FAULT);
`endif
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_reset = sys_reset_q;
   assign ready     = ready_q;
`ifdef PLL_LOCK_TIMEOUT_EN
   assign fault     = fault_q;
   assign retries   = retries_q;
`else
   assign fault     = 1'b0;
   assign retries   = 4'd0;
`endif

endmodule
